// File: rtl/bcd_7seg_scanner.sv
// bcd_7seg_scanner
//   Multiplexed seven-segment driver for a packed BCD word
//   {thousands, hundreds, tens, units}. Each frame runs LOAD, then for every
//   digit (units first) a BLANK gap followed by a DRIVE window. Input data and
//   decimal points are captured only in LOAD, so a frame never tears.
//
//   Optional build macro: LEADING_ZERO_BLANK_EN
//     When defined, digits above the units digit show no segments if they and
//     every higher nibble of the captured word are zero.
//
// Ports
//   clk_1mhz       system clock
//   reset_n_ip     asynchronous active-low reset
//   bcd_data_ip    packed BCD, [3:0] units ... [15:12] thousands
//   dp_ip          decimal point request, bit i = digit i
//   seg_op         segments {g,f,e,d,c,b,a}
//   dp_op          decimal point segment
//   an_op          digit enables, bit i = digit i
//   frame_done_op  one-cycle pulse while a new frame is being latched
module bcd_7seg_scanner #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLANK_CYCLES = 8,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic                    clk_1mhz,
  input  logic                    reset_n_ip,
  input  logic [4*NUM_DIGITS-1:0] bcd_data_ip,
  input  logic [NUM_DIGITS-1:0]   dp_ip,
  output logic [6:0]              seg_op,
  output logic                    dp_op,
  output logic [NUM_DIGITS-1:0]   an_op,
  output logic                    frame_done_op
);

  localparam int unsigned MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC);
  localparam int unsigned IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // Off patterns double as the inversion masks for active-low builds.
  localparam logic                  INV     = (ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_OFF = {7{INV}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{INV}};
  localparam logic                  DP_OFF  = INV;
  localparam logic [NUM_DIGITS-1:0] AN_ONE  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    LOAD,
    BLANK,
    DRIVE
  } state_t;

  state_t                  state;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]   dp_shadow;

  logic [3:0]              drive_nib;
  logic [6:0]              drive_seg;
  logic [NUM_DIGITS-1:0]   drive_an;
  logic                    drive_dp;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;  // non-BCD nibble shows a dash
    endcase
  endfunction

  // Active-high view of the digit selected by idx, loaded on entry to DRIVE.
  always_comb begin
    drive_nib = shadow[{idx, 2'b00} +: 4];
    drive_seg = decode(drive_nib);
    drive_an  = AN_ONE << idx;
    drive_dp  = dp_shadow[idx];
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx != '0) && ((shadow >> {idx, 2'b00}) == '0)) begin
      drive_seg = '0;
    end
`endif
  end

  always_ff @(posedge clk_1mhz or negedge reset_n_ip) begin
    if (!reset_n_ip) begin
      state         <= LOAD;
      idx           <= '0;
      cnt           <= '0;
      shadow        <= '0;
      dp_shadow     <= '0;
      an_op         <= AN_OFF;
      seg_op        <= SEG_OFF;
      dp_op         <= DP_OFF;
      frame_done_op <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          shadow    <= bcd_data_ip;
          dp_shadow <= dp_ip;
          idx       <= '0;
          cnt       <= '0;
          // LOAD reached from reset has no entry edge to raise the pulse, so
          // it spends one extra cycle re-entering itself with the pulse high.
          if (!frame_done_op) begin
            frame_done_op <= 1'b1;
          end else begin
            frame_done_op <= 1'b0;
            state         <= BLANK;
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt    <= '0;
            state  <= DRIVE;
            an_op  <= drive_an ^ AN_OFF;
            seg_op <= drive_seg ^ SEG_OFF;
            dp_op  <= drive_dp ^ DP_OFF;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            cnt    <= '0;
            an_op  <= AN_OFF;
            seg_op <= SEG_OFF;
            dp_op  <= DP_OFF;
            if (idx == IDX_LAST) begin
              state         <= LOAD;
              frame_done_op <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= BLANK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_7seg_scanner.sv
// Testbench for bcd_7seg_scanner with REFRESH_DIV=4, BLANK_CYCLES=2,
// ACTIVE_LOW=1 (25-cycle frame). Expected outputs come from a per-cycle
// frame model: cycle k after a LOAD maps to a digit and a blank/drive phase.
module tb_bcd_7seg_scanner;

  localparam int unsigned RD = 4;
  localparam int unsigned BC = 2;
  localparam int unsigned SLOT = BC + RD;
  localparam int unsigned FR = 4 * SLOT + 1;

  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam logic [12:0] RST_VEC = {4'hF, 7'h7F, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic [6:0]  seg_op;
  logic        dp_op;
  logic [3:0]  an_op;
  logic        frame_done_op;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  bcd_7seg_scanner #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk_1mhz     (clk),
    .reset_n_ip   (rst_n),
    .bcd_data_ip  (bcd),
    .dp_ip        (dp),
    .seg_op       (seg_op),
    .dp_op        (dp_op),
    .an_op        (an_op),
    .frame_done_op(frame_done_op)
  );

  // Expected {an, seg, dp, frame_done} k cycles after a LOAD cycle, for a
  // frame that captured value v and decimal points d.
  function automatic logic [12:0] model(input int unsigned k, input logic [15:0] v,
                                        input logic [3:0] d);
    logic [3:0]  an  = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic        dpo = 1'b1;
    logic [6:0]  code;
    int unsigned ph, dig, nib, upper;
    ph = k % FR;
    if (ph != 0) begin
      dig = (ph - 1) / SLOT;
      if (((ph - 1) % SLOT) >= BC) begin
        upper = int'(v) / (16 ** dig);
        nib   = upper % 16;
        code  = (nib < 10) ? SEG_TAB[nib] : 7'h40;
`ifdef LEADING_ZERO_BLANK_EN
        if (dig > 0 && upper == 0) code = 7'h00;
`endif
        an  = ~(4'd1 << dig);
        seg = ~code;
        dpo = ~d[dig];
      end
    end
    return {an, seg, dpo, (ph == 0)};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench sampled inside a LOAD cycle (k = 0).
  task automatic wait_frame(input string name);
    bit found = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      if (frame_done_op === 1'b1) begin
        found = 1;
        break;
      end
    end
    n_total++;
    if (!found) $display("FAIL %s frame_done timeout: got none within %0d cycles", name, 2 * FR);
    else n_pass++;
  endtask

  task automatic test_reset;
    logic [12:0] obs;
    rst_n = 1'b0;
    bcd   = 16'h1234;
    dp    = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {an_op, seg_op, dp_op, frame_done_op};
      n_total++;
      if (obs !== RST_VEC) $display("FAIL reset_hold cyc=%0d got %h exp %h", i, obs, RST_VEC);
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    obs = {an_op, seg_op, dp_op, frame_done_op};
    n_total++;
    if (obs !== model(0, bcd, dp)) $display("FAIL reset_first_load got %h exp %h", obs, model(0, bcd, dp));
    else n_pass++;
  endtask

  task automatic test_digit_scan;
    logic [12:0] obs, exp;
    logic [15:0] v;
    logic [3:0]  d;
    for (int f = 0; f < 6; f++) begin
      if (f == 0) begin
        v = 16'h1234;
        d = 4'h0;
      end else begin
        for (int n = 0; n < 4; n++) v[4*n +: 4] = 4'($urandom_range(9));
        d = 4'($urandom);
      end
      bcd = v;
      dp  = d;
      wait_frame("scan");
      for (int unsigned k = 1; k <= FR; k++) begin
        step();
        obs = {an_op, seg_op, dp_op, frame_done_op};
        exp = model(k, v, d);
        n_total++;
        if (obs !== exp) $display("FAIL scan v=%h k=%0d got %h exp %h", v, k, obs, exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_midframe_change;
    logic [12:0] obs, exp;
    bcd = 16'h1234;
    dp  = 4'h0;
    wait_frame("midframe");
    for (int unsigned k = 1; k <= FR; k++) begin
      step();
      obs = {an_op, seg_op, dp_op, frame_done_op};
      exp = model(k, 16'h1234, 4'h0);
      n_total++;
      if (obs !== exp) $display("FAIL midframe_old k=%0d got %h exp %h", k, obs, exp);
      else n_pass++;
      if (k == 10) bcd = 16'h5678;
    end
    for (int unsigned k = 1; k <= FR; k++) begin
      step();
      obs = {an_op, seg_op, dp_op, frame_done_op};
      exp = model(k, 16'h5678, 4'h0);
      n_total++;
      if (obs !== exp) $display("FAIL midframe_new k=%0d got %h exp %h", k, obs, exp);
      else n_pass++;
    end
  endtask

  task automatic test_invalid_nibbles;
    logic [12:0] obs, exp;
    logic [15:0] v;
    for (int f = 0; f < 4; f++) begin
      v   = (f == 0) ? 16'h00A9 : 16'($urandom) | 16'h0A00;
      bcd = v;
      dp  = 4'h0;
      wait_frame("invalid");
      for (int unsigned k = 1; k <= FR; k++) begin
        step();
        obs = {an_op, seg_op, dp_op, frame_done_op};
        exp = model(k, v, 4'h0);
        n_total++;
        if (obs !== exp) $display("FAIL invalid v=%h k=%0d got %h exp %h", v, k, obs, exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_leading_zero;
    logic [12:0] obs, exp;
    logic [15:0] vals [5] = '{16'h0007, 16'h0000, 16'h0070, 16'h0100, 16'h1000};
    foreach (vals[i]) begin
      bcd = vals[i];
      dp  = 4'hF;
      wait_frame("lzb");
      for (int unsigned k = 1; k <= FR; k++) begin
        step();
        obs = {an_op, seg_op, dp_op, frame_done_op};
        exp = model(k, vals[i], 4'hF);
        n_total++;
        if (obs !== exp) $display("FAIL lzb v=%h k=%0d got %h exp %h", vals[i], k, obs, exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_dp;
    logic [12:0] obs, exp;
    logic [15:0] v;
    v   = 16'h9081;
    bcd = v;
    dp  = 4'b0100;
    wait_frame("dp");
    for (int unsigned k = 1; k <= FR; k++) begin
      step();
      obs = {an_op, seg_op, dp_op, frame_done_op};
      exp = model(k, v, 4'b0100);
      n_total++;
      if (obs !== exp) $display("FAIL dp k=%0d got %h exp %h", k, obs, exp);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset;
    logic [12:0] obs, exp;
    bcd = 16'h4321;
    dp  = 4'h2;
    wait_frame("async");
    for (int i = 0; i < 15; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    obs = {an_op, seg_op, dp_op, frame_done_op};
    n_total++;
    if (obs !== RST_VEC) $display("FAIL async_reset_immediate got %h exp %h", obs, RST_VEC);
    else n_pass++;
    step();
    step();
    obs = {an_op, seg_op, dp_op, frame_done_op};
    n_total++;
    if (obs !== RST_VEC) $display("FAIL async_reset_held got %h exp %h", obs, RST_VEC);
    else n_pass++;
    bcd = 16'h8765;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    obs = {an_op, seg_op, dp_op, frame_done_op};
    n_total++;
    if (obs !== model(0, 16'h8765, 4'h2)) $display("FAIL async_release_load got %h exp %h", obs, model(0, 16'h8765, 4'h2));
    else n_pass++;
    for (int unsigned k = 1; k <= FR; k++) begin
      step();
      obs = {an_op, seg_op, dp_op, frame_done_op};
      exp = model(k, 16'h8765, 4'h2);
      n_total++;
      if (obs !== exp) $display("FAIL async_after k=%0d got %h exp %h", k, obs, exp);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_digit_scan();
    test_midframe_change();
    test_invalid_nibbles();
    test_leading_zero();
    test_dp();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
